// File: rtl/instr_fetch_register.sv
// Multi-byte instruction fetch register: assembles WORDS bus bytes big-endian into an
// opcode/operand pair, hands it to the control unit with valid/ack, and drives the operand back onto the bus.
module instr_fetch_register #(
    parameter int BUS_W    = 8,
    parameter int OPCODE_W = 4,
    parameter int WORDS    = 2,
    localparam int OPERAND_W = BUS_W * WORDS - OPCODE_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 n_load,
    input  logic                 n_enable,
    input  logic [BUS_W-1:0]     bus_in,
    input  logic                 instr_ack,
    output logic [BUS_W-1:0]     bus_out,
    output logic                 bus_oe,
    output logic [OPCODE_W-1:0]  opcode,
    output logic [OPERAND_W-1:0] operand,
    output logic                 instr_valid,
    output logic [2:0]           fill_count,
    output logic                 load_err
);

    localparam int         WORD_W  = BUS_W * WORDS;
    localparam logic [2:0] LAST_C  = 3'(WORDS - 1);
    localparam logic [2:0] WORDS_C = 3'(WORDS);

    typedef enum logic [1:0] {ST_EMPTY, ST_FILLING, ST_FULL} state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [2:0]            r_count;
    logic [2:0]            w_count_next;
    logic [2:0]            w_base_count;
    logic [WORD_W-1:0]     r_staging;
    logic [WORD_W-1:0]     w_new_word;
    logic [OPCODE_W-1:0]   r_opcode;
    logic [OPERAND_W-1:0]  r_operand;
    logic                  r_load_err;
    logic                  w_ack_full;
    logic                  w_load_accept;
    logic                  w_load_blocked;
    logic                  w_complete;
    logic [BUS_W-1:0]      w_bus_data;

    // An ack in FULL empties the register first, so a same-edge load lands in byte0.
    always_comb begin
        w_ack_full     = (r_state == ST_FULL) && instr_ack;
        w_load_accept  = !n_load && ((r_state != ST_FULL) || instr_ack);
        w_load_blocked = !n_load && (r_state == ST_FULL) && !instr_ack;
        w_base_count   = w_ack_full ? 3'd0 : r_count;
        w_new_word     = w_ack_full ? '0 : r_staging;
        if (w_load_accept) begin
            for (int i = 0; i < WORDS; i++) begin
                if (w_base_count == 3'(i)) begin
                    w_new_word[BUS_W*(WORDS-i)-1 -: BUS_W] = bus_in;
                end
            end
        end
        w_complete = w_load_accept && (w_base_count == LAST_C);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: the state is a pure function of the next fill count
    always_comb begin
        w_count_next = w_load_accept ? (w_base_count + 3'd1) : w_base_count;
        if (w_count_next == 3'd0) begin
            w_state_next = ST_EMPTY;
        end else if (w_count_next == WORDS_C) begin
            w_state_next = ST_FULL;
        end else begin
            w_state_next = ST_FILLING;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_count    <= '0;
            r_staging  <= '0;
            r_opcode   <= '0;
            r_operand  <= '0;
            r_load_err <= 1'b0;
        end else begin
            r_count   <= w_count_next;
            r_staging <= w_new_word;
            if (w_complete) begin
                r_opcode  <= w_new_word[WORD_W-1 -: OPCODE_W];
                r_operand <= w_new_word[OPERAND_W-1:0];
            end
            if (w_load_blocked) begin
                r_load_err <= 1'b1;
            end
        end
    end

    generate
        if (OPERAND_W >= BUS_W) begin : g_bus_trunc
            assign w_bus_data = r_operand[BUS_W-1:0];
        end else begin : g_bus_zext
            assign w_bus_data = {{(BUS_W - OPERAND_W){1'b0}}, r_operand};
        end
    endgenerate

    // Output logic
    always_comb begin
        instr_valid = (r_state == ST_FULL);
        bus_oe      = !n_enable && (r_state == ST_FULL);
        bus_out     = bus_oe ? w_bus_data : '0;
    end

    assign opcode     = r_opcode;
    assign operand    = r_operand;
    assign fill_count = r_count;
    assign load_err   = r_load_err;

endmodule

// File: tb/tb_instr_fetch_register.sv
// Self-checking bench: default 2-byte instance driven through a scoreboard of completed
// instructions, plus a single-byte instance for the WORDS=1 corner cases.
module tb_instr_fetch_register;

    logic       clk = 1'b0;
    logic       rst_n, clear, n_load, n_load1, n_enable, instr_ack;
    logic [7:0] bus_in;

    logic [7:0]  bus_out, bus_out1;
    logic        bus_oe, bus_oe1;
    logic [3:0]  opcode, opcode1;
    logic [11:0] operand;
    logic [3:0]  operand1;
    logic        instr_valid, instr_valid1;
    logic [2:0]  fill_count, fill_count1;
    logic        load_err, load_err1;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct packed {
        logic [3:0]  op;
        logic [11:0] opd;
    } instr_t;

    instr_t exp_q[$];

    instr_fetch_register dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .n_load(n_load), .n_enable(n_enable),
        .bus_in(bus_in), .instr_ack(instr_ack), .bus_out(bus_out), .bus_oe(bus_oe),
        .opcode(opcode), .operand(operand), .instr_valid(instr_valid),
        .fill_count(fill_count), .load_err(load_err)
    );

    instr_fetch_register #(.BUS_W(8), .OPCODE_W(4), .WORDS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .n_load(n_load1), .n_enable(n_enable),
        .bus_in(bus_in), .instr_ack(instr_ack), .bus_out(bus_out1), .bus_oe(bus_oe1),
        .opcode(opcode1), .operand(operand1), .instr_valid(instr_valid1),
        .fill_count(fill_count1), .load_err(load_err1)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for instr_valid, then pop the scoreboard and compare.
    task automatic drain_scoreboard(input string name);
        instr_t e;
        for (int k = 0; k < 4 && !instr_valid; k++) cyc();
        n_total++;
        if (instr_valid !== 1'b1 || exp_q.size() == 0) begin
            $display("FAIL %s timeout: instr_valid=%b queued=%0d want valid=1 queued>0",
                     name, instr_valid, exp_q.size());
        end else begin
            e = exp_q.pop_front();
            if (opcode !== e.op || operand !== e.opd)
                $display("FAIL %s: got opcode=%h operand=%h want opcode=%h operand=%h",
                         name, opcode, operand, e.op, e.opd);
            else n_pass++;
        end
    endtask

    task automatic load_pair(input logic [7:0] b0, input logic [7:0] b1);
        exp_q.push_back({b0, b1});
        n_load = 1'b0; bus_in = b0; cyc();
        bus_in = b1; cyc();
        n_load = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clear = 1'b0; n_load = 1'b0; n_load1 = 1'b0;
        n_enable = 1'b0; instr_ack = 1'b0; bus_in = 8'hFF;
        cyc(); cyc();
        n_total++;
        if ({opcode, operand, instr_valid, fill_count, load_err, bus_oe, bus_out} !== '0)
            $display("FAIL reset_outputs: got op=%h opd=%h v=%b cnt=%0d err=%b oe=%b bus=%h want all 0",
                     opcode, operand, instr_valid, fill_count, load_err, bus_oe, bus_out);
        else n_pass++;
        n_total++;
        if ({opcode1, operand1, instr_valid1, fill_count1, load_err1, bus_oe1, bus_out1} !== '0)
            $display("FAIL reset_outputs_w1: got op=%h opd=%h v=%b cnt=%0d want all 0",
                     opcode1, operand1, instr_valid1, fill_count1);
        else n_pass++;
        rst_n = 1'b1; n_load = 1'b1; n_load1 = 1'b1; n_enable = 1'b1;
        cyc();
    endtask

    task automatic test_load();
        exp_q.push_back({8'h3A, 8'hBC});
        n_load = 1'b0; bus_in = 8'h3A; cyc();
        n_total++;
        if (fill_count !== 3'd1 || instr_valid !== 1'b0)
            $display("FAIL load_first_byte: got cnt=%0d v=%b want cnt=1 v=0", fill_count, instr_valid);
        else n_pass++;
        bus_in = 8'hBC; cyc();
        n_load = 1'b1;
        drain_scoreboard("load_complete");
        n_total++;
        if (fill_count !== 3'd2)
            $display("FAIL load_fill_count: got %0d want 2", fill_count);
        else n_pass++;
    endtask

    task automatic test_bus_drive();
        n_enable = 1'b0; #1;
        n_total++;
        if (bus_oe !== 1'b1 || bus_out !== 8'hBC)
            $display("FAIL bus_drive_full: got oe=%b bus=%h want oe=1 bus=bc", bus_oe, bus_out);
        else n_pass++;
        n_enable = 1'b1; #1;
        n_total++;
        if (bus_oe !== 1'b0 || bus_out !== 8'h00)
            $display("FAIL bus_release: got oe=%b bus=%h want oe=0 bus=00", bus_oe, bus_out);
        else n_pass++;
    endtask

    task automatic test_load_err();
        n_load = 1'b0; bus_in = 8'h77; cyc();
        n_load = 1'b1;
        n_total++;
        if (operand !== 12'hABC || load_err !== 1'b1 || fill_count !== 3'd2 || instr_valid !== 1'b1)
            $display("FAIL load_while_full: got opd=%h err=%b cnt=%0d v=%b want opd=abc err=1 cnt=2 v=1",
                     operand, load_err, fill_count, instr_valid);
        else n_pass++;
        cyc();
        n_total++;
        if (load_err !== 1'b1)
            $display("FAIL load_err_sticky: got %b want 1", load_err);
        else n_pass++;
        clear = 1'b1; cyc();
        clear = 1'b0;
        n_total++;
        if ({opcode, operand, instr_valid, fill_count, load_err} !== '0)
            $display("FAIL clear_outputs: got op=%h opd=%h v=%b cnt=%0d err=%b want all 0",
                     opcode, operand, instr_valid, fill_count, load_err);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        load_pair(8'h3A, 8'hBC);
        drain_scoreboard("refill_complete");
        instr_ack = 1'b1; n_load = 1'b0; bus_in = 8'h51; cyc();
        instr_ack = 1'b0; n_load = 1'b1;
        n_total++;
        if (instr_valid !== 1'b0 || fill_count !== 3'd1 || opcode !== 4'h3)
            $display("FAIL ack_and_load: got v=%b cnt=%0d op=%h want v=0 cnt=1 op=3",
                     instr_valid, fill_count, opcode);
        else n_pass++;
        n_enable = 1'b0; #1;
        n_total++;
        if (bus_oe !== 1'b0 || bus_out !== 8'h00)
            $display("FAIL no_drive_filling: got oe=%b bus=%h want oe=0 bus=00", bus_oe, bus_out);
        else n_pass++;
        n_enable = 1'b1;
        exp_q.push_back({8'h51, 8'h22});
        n_load = 1'b0; bus_in = 8'h22; cyc();
        n_load = 1'b1;
        drain_scoreboard("second_instr");
        instr_ack = 1'b1; cyc();
        instr_ack = 1'b0;
        n_total++;
        if (instr_valid !== 1'b0 || fill_count !== 3'd0 || opcode !== 4'h5 || operand !== 12'h122)
            $display("FAIL ack_hold: got v=%b cnt=%0d op=%h opd=%h want v=0 cnt=0 op=5 opd=122",
                     instr_valid, fill_count, opcode, operand);
        else n_pass++;
        instr_ack = 1'b1; cyc();
        instr_ack = 1'b0;
        n_total++;
        if (instr_valid !== 1'b0 || fill_count !== 3'd0)
            $display("FAIL ack_empty_ignored: got v=%b cnt=%0d want v=0 cnt=0", instr_valid, fill_count);
        else n_pass++;
    endtask

    task automatic test_words1();
        n_load1 = 1'b0; bus_in = 8'h2F; cyc();
        n_load1 = 1'b1;
        n_total++;
        if (instr_valid1 !== 1'b1 || opcode1 !== 4'h2 || operand1 !== 4'hF || fill_count1 !== 3'd1)
            $display("FAIL w1_load: got v=%b op=%h opd=%h cnt=%0d want v=1 op=2 opd=f cnt=1",
                     instr_valid1, opcode1, operand1, fill_count1);
        else n_pass++;
        n_enable = 1'b0; #1;
        n_total++;
        if (bus_oe1 !== 1'b1 || bus_out1 !== 8'h0F || bus_oe !== 1'b0)
            $display("FAIL w1_bus_zext: got oe=%b bus=%h main_oe=%b want oe=1 bus=0f main_oe=0",
                     bus_oe1, bus_out1, bus_oe);
        else n_pass++;
        n_enable = 1'b1;
        instr_ack = 1'b1; n_load1 = 1'b0; bus_in = 8'h91; cyc();
        instr_ack = 1'b0; n_load1 = 1'b1;
        n_total++;
        if (instr_valid1 !== 1'b1 || opcode1 !== 4'h9 || operand1 !== 4'h1 || load_err1 !== 1'b0)
            $display("FAIL w1_ack_reload: got v=%b op=%h opd=%h err=%b want v=1 op=9 opd=1 err=0",
                     instr_valid1, opcode1, operand1, load_err1);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        n_load = 1'b0; bus_in = 8'h44; cyc();
        n_load = 1'b1;
        n_total++;
        if (fill_count !== 3'd1)
            $display("FAIL mid_fill_count: got %0d want 1", fill_count);
        else n_pass++;
        rst_n = 1'b0; cyc();
        rst_n = 1'b1;
        n_total++;
        if (fill_count !== 3'd0 || instr_valid1 !== 1'b0)
            $display("FAIL mid_fill_reset: got cnt=%0d w1_v=%b want cnt=0 w1_v=0", fill_count, instr_valid1);
        else n_pass++;
        load_pair(8'hA1, 8'hB2);
        drain_scoreboard("restart_byte0");
    endtask

    initial begin
        test_reset();
        test_load();
        test_bus_drive();
        test_load_err();
        test_back_to_back();
        test_words1();
        test_mid_reset();
        n_total++;
        if (exp_q.size() != 0)
            $display("FAIL scoreboard_empty: got %0d entries left want 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
